// File: rtl/lc3_dp_pkg.sv
// Shared select encodings, memory-FSM states and the immediate sign-extender.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package lc3_dp_pkg;

    // Widest datapath the sign-extender can serve; DATA_W must not exceed it.
    localparam int SEXT_MAX_W = 64;

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_ADDR = 2'd1,
        PC_BUS  = 2'd2,
        PC_HOLD = 2'd3
    } pcmux_e;

    typedef enum logic [1:0] {
        A2_ZERO  = 2'd0,
        A2_OFF6  = 2'd1,
        A2_OFF9  = 2'd2,
        A2_OFF11 = 2'd3
    } addr2mux_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_AND  = 2'd1,
        ALU_NOT  = 2'd2,
        ALU_PASS = 2'd3
    } aluk_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memfsm_e;

    // Sign-extend the low 'width' bits of an IR-sized field; callers truncate to DATA_W.
    function automatic logic [SEXT_MAX_W-1:0] sext(input logic [15:0] raw, input int width);
        logic [SEXT_MAX_W-1:0] res;
        res = {SEXT_MAX_W{raw[4'(width - 1)]}};
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                res[i] = raw[4'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lc3_regfile_p.sv
// Eight-entry register file, two asynchronous read ports and one write port.
// Latency: reads combinational; a write is visible after the loading edge (same-cycle read sees the old value).
// Backpressure: none; the write enable is taken unconditionally.
module lc3_regfile_p #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [2:0]        dr,
    input  logic [DATA_W-1:0] din,
    input  logic [2:0]        sr1,
    input  logic [2:0]        sr2,
    output logic [DATA_W-1:0] sr1_dat,
    output logic [DATA_W-1:0] sr2_dat
);

    logic [DATA_W-1:0] regs [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[dr] <= din;
        end
    end

    assign sr1_dat = regs[sr1];
    assign sr2_dat = regs[sr2];

endmodule

// File: rtl/lc3_datapath_p.sv
// LC-3 datapath with checked internal bus and a req/ack memory engine that aborts after MEM_TIMEOUT cycles.
// Latency: register loads on the next edge; memory access start-to-mem_done is 2 cycles minimum.
// Backpressure: memory holds mem_req until mem_ack or timeout; mem_start outside IDLE is dropped.
module lc3_datapath_p
    import lc3_dp_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              LD_IR,
    input  logic              LD_MAR,
    input  logic              LD_PC,
    input  logic              LD_MDR,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic              LD_REG,
    input  logic              GatePC,
    input  logic              GateMDR,
    input  logic              GateALU,
    input  logic              GateMARMUX,
    input  logic [1:0]        PCMUX,
    input  logic              ADDR1MUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic              SR1MUX,
    input  logic              DRMUX,
    input  logic              SR2MUX,
    input  logic [1:0]        ALUK,
    input  logic              mem_start,
    input  logic              mem_we,
    output logic              mem_req,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_done,
    output logic              mem_err,
    output logic              bus_err,
    output logic [DATA_W-1:0] bus,
    output logic              BEN,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] MAR
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [DATA_W-1:0] ir_q, pc_q, mar_q, mdr_q;
    logic [2:0]        nzp_q;
    logic              ben_q;
    memfsm_e           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q, err_q;
    logic              start_acc, ack_hit, tmo_hit;

    logic [DATA_W-1:0] sx5, sx6, sx9, sx11;
    logic [2:0]        sr1_sel, dr_sel;
    logic [DATA_W-1:0] sr1_dat, sr2_dat;
    logic [DATA_W-1:0] alu_b, alu_y, addr1, addr2, addr_sum, pc_d, bus_w;
    logic [2:0]        gate_cnt;
    logic              bus_err_w;

    assign sx5  = DATA_W'(sext(ir_q[15:0], 5));
    assign sx6  = DATA_W'(sext(ir_q[15:0], 6));
    assign sx9  = DATA_W'(sext(ir_q[15:0], 9));
    assign sx11 = DATA_W'(sext(ir_q[15:0], 11));

    assign sr1_sel = SR1MUX ? ir_q[11:9] : ir_q[8:6];
    assign dr_sel  = DRMUX  ? 3'd7       : ir_q[11:9];

    lc3_regfile_p #(.DATA_W(DATA_W)) u_regfile (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .we      (LD_REG),
        .dr      (dr_sel),
        .din     (bus_w),
        .sr1     (sr1_sel),
        .sr2     (ir_q[2:0]),
        .sr1_dat (sr1_dat),
        .sr2_dat (sr2_dat)
    );

    assign alu_b = SR2MUX ? sx5 : sr2_dat;

    always_comb begin
        alu_y = sr1_dat;
        case (aluk_e'(ALUK))
            ALU_ADD:  alu_y = sr1_dat + alu_b;
            ALU_AND:  alu_y = sr1_dat & alu_b;
            ALU_NOT:  alu_y = ~sr1_dat;
            ALU_PASS: alu_y = sr1_dat;
            default:  alu_y = sr1_dat;
        endcase
    end

    assign addr1 = ADDR1MUX ? sr1_dat : pc_q;

    always_comb begin
        addr2 = '0;
        case (addr2mux_e'(ADDR2MUX))
            A2_ZERO:  addr2 = '0;
            A2_OFF6:  addr2 = sx6;
            A2_OFF9:  addr2 = sx9;
            A2_OFF11: addr2 = sx11;
            default:  addr2 = '0;
        endcase
    end

    assign addr_sum = addr1 + addr2;

    // A conflicting drive floats nothing onto the bus: it reads as zero and is flagged.
    assign gate_cnt  = {2'b0, GatePC} + {2'b0, GateMDR} + {2'b0, GateALU} + {2'b0, GateMARMUX};
    assign bus_err_w = (gate_cnt > 3'd1);

    always_comb begin
        bus_w = '0;
        if (!bus_err_w) begin
            if (GatePC)     bus_w = pc_q;
            if (GateMDR)    bus_w = mdr_q;
            if (GateALU)    bus_w = alu_y;
            if (GateMARMUX) bus_w = addr_sum;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (pcmux_e'(PCMUX))
            PC_INC:  pc_d = pc_q + DATA_W'(1);
            PC_ADDR: pc_d = addr_sum;
            PC_BUS:  pc_d = bus_w;
            PC_HOLD: pc_d = pc_q;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ir_q  <= '0;
            pc_q  <= RESET_PC;
            mar_q <= '0;
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (LD_IR)  ir_q  <= bus_w;
            if (LD_PC)  pc_q  <= pc_d;
            if (LD_MAR) mar_q <= bus_w;
            if (LD_CC) begin
                if (bus_w[DATA_W-1])  nzp_q <= 3'b100;
                else if (bus_w == '0) nzp_q <= 3'b010;
                else                  nzp_q <= 3'b001;
            end
            if (LD_BEN) ben_q <= |(ir_q[11:9] & nzp_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                start_acc = mem_start;
                if (mem_start) state_d = REQ;
            end
            REQ: begin
                ack_hit = mem_ack;
                tmo_hit = !mem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
                if (ack_hit || tmo_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (start_acc) begin
            cnt_q <= '0;
            we_q  <= mem_we;
            err_q <= 1'b0;
        end else if (state_q == REQ) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    // While a request is outstanding the FSM owns MDR; LD_MDR is ignored.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mdr_q <= '0;
        end else if (ack_hit && !we_q) begin
            mdr_q <= mem_rdata;
        end else if (LD_MDR && state_q != REQ) begin
            mdr_q <= bus_w;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we_o  = we_q && (state_q == REQ);
    assign mem_done  = (state_q == DONE);
    assign mem_err   = err_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign bus_err   = bus_err_w;
    assign bus       = bus_w;
    assign BEN       = ben_q;
    assign IR        = ir_q;
    assign PC        = pc_q;
    assign MAR       = mar_q;

endmodule

// File: tb/tb_lc3_datapath_p.sv
// Randomised scenario bench for lc3_datapath_p against an architectural LC-3 model.
module tb_lc3_datapath_p;

    localparam int          W       = 16;
    localparam logic [15:0] RST_PC  = 16'h3000;
    localparam int          TIMEOUT = 4;

    logic Clk = 1'b0;
    logic Reset_n;
    logic LD_IR, LD_MAR, LD_PC, LD_MDR, LD_CC, LD_BEN, LD_REG;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic ADDR1MUX, SR1MUX, DRMUX, SR2MUX;
    logic mem_start, mem_we, mem_req, mem_we_o, mem_ack, mem_done, mem_err, bus_err, BEN;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata, bus, IR, PC, MAR;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_reg [8];
    logic [15:0] m_pc, m_ir, m_mar, m_mdr;
    logic [2:0]  m_nzp;

    lc3_datapath_p #(.DATA_W(W), .RESET_PC(RST_PC), .MEM_TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_PC(LD_PC), .LD_MDR(LD_MDR),
        .LD_CC(LD_CC), .LD_BEN(LD_BEN), .LD_REG(LD_REG),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
        .SR1MUX(SR1MUX), .DRMUX(DRMUX), .SR2MUX(SR2MUX), .ALUK(ALUK),
        .mem_start(mem_start), .mem_we(mem_we), .mem_req(mem_req), .mem_we_o(mem_we_o),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_done(mem_done), .mem_err(mem_err), .bus_err(bus_err), .bus(bus),
        .BEN(BEN), .IR(IR), .PC(PC), .MAR(MAR)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic [15:0] mask;
        mask = 16'((1 << bits) - 1);
        v = v & mask;
        return v[bits-1] ? (v | ~mask) : v;
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ctrl_idle();
        {LD_IR, LD_MAR, LD_PC, LD_MDR, LD_CC, LD_BEN, LD_REG} = '0;
        {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
        PCMUX = 2'd0; ADDR1MUX = 1'b0; ADDR2MUX = 2'd0;
        SR1MUX = 1'b0; DRMUX = 1'b0; SR2MUX = 1'b0; ALUK = 2'd0;
        mem_start = 1'b0; mem_we = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
        m_pc = RST_PC; m_ir = 16'h0; m_mar = 16'h0; m_mdr = 16'h0; m_nzp = 3'b010;
    endtask

    task automatic mem_read(input logic [15:0] value);
        mem_we = 1'b0; mem_start = 1'b1;
        tick();
        mem_start = 1'b0; mem_ack = 1'b1; mem_rdata = value;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'($urandom);
        tick();
        m_mdr = value;
    endtask

    task automatic load_ir(input logic [15:0] value);
        mem_read(value);
        GateMDR = 1'b1; LD_IR = 1'b1;
        tick();
        GateMDR = 1'b0; LD_IR = 1'b0;
        m_ir = value;
    endtask

    task automatic set_pc(input logic [15:0] value);
        mem_read(value);
        GateMDR = 1'b1; LD_PC = 1'b1; PCMUX = 2'd2;
        tick();
        GateMDR = 1'b0; LD_PC = 1'b0; PCMUX = 2'd0;
        m_pc = value;
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [15:0] value);
        load_ir({4'h0, r, 9'h0});
        mem_read(value);
        GateMDR = 1'b1; LD_REG = 1'b1; DRMUX = 1'b0;
        tick();
        GateMDR = 1'b0; LD_REG = 1'b0;
        m_reg[r] = value;
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
        load_ir({7'h0, r, 6'h0});
        SR1MUX = 1'b0; ALUK = 2'd3; GateALU = 1'b1;
        #1 v = bus;
        GateALU = 1'b0; ALUK = 2'd0;
    endtask

    // Condition codes are not a port: recover them by branching on each flag in turn.
    task automatic probe_nzp(output logic [2:0] n);
        logic [15:0] m;
        for (int b = 0; b < 3; b++) begin
            m = 16'h0200 << b;
            load_ir(m);
            LD_BEN = 1'b1;
            tick();
            LD_BEN = 1'b0;
            n[b] = BEN;
        end
    endtask

    task automatic test_reset();
        logic [2:0] n;
        logic [15:0] v;
        checks++;
        if (PC !== RST_PC || IR !== 16'h0 || MAR !== 16'h0 || BEN !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: PC=%h IR=%h MAR=%h BEN=%b required PC=%h IR=0 MAR=0 BEN=0", PC, IR, MAR, BEN, RST_PC);
        end
        checks++;
        if ({mem_req, mem_we_o, mem_done, mem_err, bus_err} !== 5'b0 || bus !== 16'h0) begin
            failures++;
            $display("FAIL reset_outs: req/we/done/err/buserr=%b bus=%h required all 0", {mem_req, mem_we_o, mem_done, mem_err, bus_err}, bus);
        end
        PCMUX = 2'd0; LD_PC = 1'b1;
        tick(); tick();
        LD_PC = 1'b0;
        mem_we = 1'b1; mem_start = 1'b1;
        tick();
        mem_start = 1'b0; mem_we = 1'b0;
        checks++;
        if (PC !== RST_PC + 16'd2 || mem_req !== 1'b1 || mem_we_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: PC=%h req=%b we=%b required PC=%h req=1 we=1", PC, mem_req, mem_we_o, RST_PC + 16'd2);
        end
        #3 Reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (PC !== RST_PC || mem_req !== 1'b0 || mem_we_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: PC=%h req=%b we=%b required PC=%h req=0 we=0", PC, mem_req, mem_we_o, RST_PC);
        end
        Reset_n = 1'b1;
        probe_nzp(n);
        checks++;
        if (n !== m_nzp) begin
            failures++;
            $display("FAIL reset_nzp: got %b required %b", n, m_nzp);
        end
        read_reg(3'd5, v);
        checks++;
        if (v !== 16'h0) begin
            failures++;
            $display("FAIL reset_reg: R5=%h required 0000", v);
        end
    endtask

    task automatic test_add_neg1();
        logic [2:0] n;
        logic [15:0] v;
        write_reg(3'd1, 16'h0);
        load_ir(16'h127F);
        SR1MUX = 1'b0; SR2MUX = 1'b1; ALUK = 2'd0; DRMUX = 1'b0;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        #1;
        checks++;
        if (bus !== 16'hFFFF) begin
            failures++;
            $display("FAIL add_neg1_bus: bus=%h required ffff", bus);
        end
        tick();
        ctrl_idle();
        m_reg[1] = 16'hFFFF; m_nzp = 3'b100;
        read_reg(3'd1, v);
        checks++;
        if (v !== 16'hFFFF) begin
            failures++;
            $display("FAIL add_neg1_r1: R1=%h required ffff", v);
        end
        probe_nzp(n);
        checks++;
        if (n !== 3'b100) begin
            failures++;
            $display("FAIL add_neg1_nzp: got %b required 100", n);
        end
    endtask

    task automatic test_alu_random();
        logic [2:0] sr1, sr2, dr, n;
        logic [1:0] op;
        logic imm;
        logic [4:0] imm5;
        logic [15:0] a, b, exp, v;
        for (int it = 0; it < 6; it++) begin
            sr1 = 3'($urandom); sr2 = 3'($urandom); dr = 3'($urandom);
            op = 2'($urandom); imm = 1'($urandom); imm5 = 5'($urandom);
            write_reg(sr1, 16'($urandom));
            write_reg(sr2, (it == 0) ? 16'h0 : 16'($urandom));
            load_ir({4'h1, dr, sr1, imm, imm ? imm5 : {2'b00, sr2}});
            a = m_reg[sr1];
            b = imm ? sx({11'h0, imm5}, 5) : m_reg[sr2];
            case (op)
                2'd0: exp = a + b;
                2'd1: exp = a & b;
                2'd2: exp = ~a;
                default: exp = a;
            endcase
            SR1MUX = 1'b0; SR2MUX = imm; ALUK = op; DRMUX = 1'b0;
            GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            #1;
            checks++;
            if (bus !== exp) begin
                failures++;
                $display("FAIL alu_bus[%0d]: op=%0d bus=%h required %h", it, op, bus, exp);
            end
            tick();
            ctrl_idle();
            m_reg[dr] = exp; m_nzp = nzp_of(exp);
            read_reg(dr, v);
            checks++;
            if (v !== exp) begin
                failures++;
                $display("FAIL alu_dr[%0d]: R%0d=%h required %h", it, dr, v, exp);
            end
            probe_nzp(n);
            checks++;
            if (n !== m_nzp) begin
                failures++;
                $display("FAIL alu_nzp[%0d]: got %b required %b", it, n, m_nzp);
            end
        end
    endtask

    task automatic test_addr_random();
        logic [15:0] instr, a1, a2, exp;
        logic s1m, a1m;
        logic [1:0] a2m;
        logic [2:0] idx;
        for (int it = 0; it < 6; it++) begin
            instr = 16'($urandom); s1m = 1'($urandom); a1m = 1'($urandom); a2m = 2'($urandom);
            idx = s1m ? instr[11:9] : instr[8:6];
            write_reg(idx, 16'($urandom));
            load_ir(instr);
            set_pc(16'($urandom));
            a1 = a1m ? m_reg[idx] : m_pc;
            case (a2m)
                2'd0: a2 = 16'h0;
                2'd1: a2 = sx(instr, 6);
                2'd2: a2 = sx(instr, 9);
                default: a2 = sx(instr, 11);
            endcase
            exp = a1 + a2;
            SR1MUX = s1m; ADDR1MUX = a1m; ADDR2MUX = a2m; GateMARMUX = 1'b1;
            PCMUX = 2'd1; LD_PC = 1'b1; LD_MAR = 1'b1;
            #1;
            checks++;
            if (bus !== exp) begin
                failures++;
                $display("FAIL addr_bus[%0d]: a1m=%b a2m=%0d bus=%h required %h", it, a1m, a2m, bus, exp);
            end
            tick();
            ctrl_idle();
            m_pc = exp; m_mar = exp;
            checks++;
            if (PC !== m_pc || MAR !== m_mar) begin
                failures++;
                $display("FAIL addr_load[%0d]: PC=%h MAR=%h required %h", it, PC, MAR, exp);
            end
        end
    endtask

    task automatic test_mem_read();
        mem_read(16'h0030);
        GateMDR = 1'b1; LD_MAR = 1'b1;
        tick();
        ctrl_idle();
        m_mar = 16'h0030;
        mem_we = 1'b0; mem_start = 1'b1;
        tick();
        mem_start = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we_o !== 1'b0 || mem_done !== 1'b0 || mem_addr !== 16'h0030) begin
            failures++;
            $display("FAIL read_req: req=%b we=%b done=%b addr=%h required 1 0 0 0030", mem_req, mem_we_o, mem_done, mem_addr);
        end
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        m_mdr = 16'hBEEF;
        checks++;
        if (mem_done !== 1'b1 || mem_req !== 1'b0 || mem_wdata !== m_mdr || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL read_done: done=%b req=%b mdr=%h err=%b required 1 0 %h 0", mem_done, mem_req, mem_wdata, mem_err, m_mdr);
        end
        tick();
        checks++;
        if (mem_done !== 1'b0) begin
            failures++;
            $display("FAIL read_done_pulse: done=%b required 0", mem_done);
        end
        mem_start = 1'b1;
        tick();
        mem_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1357;
        tick();
        mem_ack = 1'b0;
        m_mdr = 16'h1357;
        checks++;
        if (mem_done !== 1'b1 || mem_wdata !== m_mdr) begin
            failures++;
            $display("FAIL read_min_latency: done=%b mdr=%h required 1 %h", mem_done, mem_wdata, m_mdr);
        end
        tick();
    endtask

    task automatic test_mem_write();
        mem_we = 1'b1; mem_start = 1'b1;
        tick();
        mem_start = 1'b0; mem_we = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we_o !== 1'b1 || mem_wdata !== m_mdr || mem_addr !== m_mar) begin
            failures++;
            $display("FAIL write_req: req=%b we=%b wdata=%h addr=%h required 1 1 %h %h", mem_req, mem_we_o, mem_wdata, mem_addr, m_mdr, m_mar);
        end
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_done !== 1'b1 || mem_wdata !== m_mdr) begin
            failures++;
            $display("FAIL write_done: done=%b mdr=%h required 1 %h", mem_done, mem_wdata, m_mdr);
        end
        tick();
    endtask

    task automatic test_timeout();
        int done_at;
        int req_cycles;
        set_pc(16'h4321);
        mem_we = 1'b0; mem_start = 1'b1;
        tick();
        mem_start = 1'b0;
        GatePC = 1'b1; LD_MDR = 1'b1;
        done_at = 0; req_cycles = 0;
        for (int n = 1; n <= 20; n++) begin
            if (mem_done) begin
                done_at = n;
                break;
            end
            if (mem_req) req_cycles++;
            if (n == 3) begin
                GatePC = 1'b0; LD_MDR = 1'b0;
            end
            tick();
        end
        ctrl_idle();
        checks++;
        if (done_at !== TIMEOUT + 1 || req_cycles !== TIMEOUT) begin
            failures++;
            $display("FAIL timeout_latency: done at cycle %0d after %0d req cycles, required %0d and %0d", done_at, req_cycles, TIMEOUT + 1, TIMEOUT);
        end
        checks++;
        if (mem_err !== 1'b1 || mem_wdata !== m_mdr) begin
            failures++;
            $display("FAIL timeout_err: err=%b mdr=%h required 1 %h", mem_err, mem_wdata, m_mdr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_err !== 1'b1 || mem_done !== 1'b0 || mem_wdata !== m_mdr) begin
            failures++;
            $display("FAIL idle_ack: err=%b done=%b mdr=%h required 1 0 %h", mem_err, mem_done, mem_wdata, m_mdr);
        end
        mem_start = 1'b1;
        tick();
        mem_start = 1'b0;
        checks++;
        if (mem_err !== 1'b0 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL err_clear: err=%b req=%b required 0 1", mem_err, mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 16'h2468;
        tick();
        mem_ack = 1'b0;
        m_mdr = 16'h2468;
        tick();
    endtask

    task automatic test_bus_conflict();
        set_pc(16'h1234);
        GatePC = 1'b1; GateALU = 1'b1; LD_MAR = 1'b1;
        #1;
        checks++;
        if (bus_err !== 1'b1 || bus !== 16'h0) begin
            failures++;
            $display("FAIL conflict_bus: bus_err=%b bus=%h required 1 0000", bus_err, bus);
        end
        tick();
        ctrl_idle();
        m_mar = 16'h0;
        checks++;
        if (MAR !== m_mar) begin
            failures++;
            $display("FAIL conflict_load: MAR=%h required 0000", MAR);
        end
        GatePC = 1'b1;
        #1;
        checks++;
        if (bus_err !== 1'b0 || bus !== m_pc) begin
            failures++;
            $display("FAIL single_gate: bus_err=%b bus=%h required 0 %h", bus_err, bus, m_pc);
        end
        GatePC = 1'b0; GateMDR = 1'b1; GateMARMUX = 1'b1;
        #1;
        checks++;
        if (bus_err !== 1'b1 || bus !== 16'h0) begin
            failures++;
            $display("FAIL conflict_mdr_marmux: bus_err=%b bus=%h required 1 0000", bus_err, bus);
        end
        ctrl_idle();
    endtask

    task automatic test_branch();
        mem_read(16'h0005);
        GateMDR = 1'b1; LD_CC = 1'b1;
        tick();
        ctrl_idle();
        m_nzp = nzp_of(16'h0005);
        load_ir(16'h0A05);
        LD_BEN = 1'b1;
        tick();
        LD_BEN = 1'b0;
        checks++;
        if (BEN !== (|(m_ir[11:9] & m_nzp))) begin
            failures++;
            $display("FAIL ben_taken: BEN=%b required 1", BEN);
        end
        LD_BEN = 1'b1; LD_CC = 1'b1;
        tick();
        LD_BEN = 1'b0; LD_CC = 1'b0;
        checks++;
        if (BEN !== 1'b1) begin
            failures++;
            $display("FAIL ben_old_nzp: BEN=%b required 1", BEN);
        end
        m_nzp = 3'b010;
        LD_BEN = 1'b1;
        tick();
        LD_BEN = 1'b0;
        checks++;
        if (BEN !== (|(m_ir[11:9] & m_nzp))) begin
            failures++;
            $display("FAIL ben_not_taken: BEN=%b required 0", BEN);
        end
        set_pc(16'hFFFF);
        PCMUX = 2'd0; LD_PC = 1'b1;
        tick();
        m_pc = m_pc + 16'd1;
        checks++;
        if (PC !== m_pc) begin
            failures++;
            $display("FAIL pc_wrap: PC=%h required %h", PC, m_pc);
        end
        PCMUX = 2'd3;
        tick();
        ctrl_idle();
        checks++;
        if (PC !== m_pc) begin
            failures++;
            $display("FAIL pc_hold: PC=%h required %h", PC, m_pc);
        end
    endtask

    initial begin
        ctrl_idle();
        mem_rdata = 16'h0;
        Reset_n = 1'b0;
        model_reset();
        #12 Reset_n = 1'b1;
        test_reset();
        test_add_neg1();
        test_alu_random();
        test_addr_random();
        test_mem_read();
        test_mem_write();
        test_timeout();
        test_bus_conflict();
        test_branch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
